// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared constants for count_monitor.
//   ST_*          : FSM state encodings (2 bits; encoding 3 is unused and
//                   decodes to IDLE)
//   *_DEF         : default parameter values for count_monitor
package count_mon_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  localparam int CW_DEF       = 4;
  localparam int MAX_HOLD_DEF = 3;
  localparam int WC_W_DEF     = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous up-counter that sticks at MAX.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q -> 0)
//   inc   : count up by one unless already at MAX
//   clr   : synchronous clear, wins over inc
//   q     : current count
module sat_counter #(
  parameter int         W   = 8,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                q <= '0;
    else if (clr)              q <= '0;
    else if (inc && q != MAX)  q <= q + 1'b1;
  end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: watches an upstream free-running counter and classifies
// every sample as a legal step, a wrap (max->0), a restart (x->0), a hold
// (unchanged) or an illegal step. All outputs are registered, one clock
// after the sample.
//   clk           : rising-edge clock
//   reset         : asynchronous active-low reset
//   count [CW]    : monitored counter value
//   clr           : synchronous clear of sticky status, FSM back to IDLE
//   wrap_pulse    : one-cycle pulse after a max->0 step
//   restart_pulse : one-cycle pulse after a jump to 0 from a non-max value
//   wrap_count    : saturating number of wraps
//   stall         : count unchanged for MAX_HOLD or more samples
//   step_err      : sticky illegal-step flag
//   err_value     : sample that raised step_err
//   state         : FSM state (IDLE/TRACK/ERR)
module count_monitor import count_mon_pkg::*; #(
  parameter int CW       = CW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int WC_W     = WC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CW-1:0]   count,
  input  logic            clr,
  output logic            wrap_pulse,
  output logic            restart_pulse,
  output logic [WC_W-1:0] wrap_count,
  output logic            stall,
  output logic            step_err,
  output logic [CW-1:0]   err_value,
  output logic [1:0]      state
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic [CW-1:0] prev, prev_d, prev_inc, err_value_d;
  logic [1:0]    state_d;
  logic [HW-1:0] hold;
  logic          stall_d, step_err_d, wrap_pulse_d, restart_pulse_d;
  logic          wc_inc, wc_clr, hold_inc, hold_clr;

  assign prev_inc = prev + 1'b1;

  always_comb begin
    state_d         = state;
    prev_d          = prev;
    stall_d         = stall;
    step_err_d      = step_err;
    err_value_d     = err_value;
    wrap_pulse_d    = 1'b0;
    restart_pulse_d = 1'b0;
    wc_inc          = 1'b0;
    wc_clr          = 1'b0;
    hold_inc        = 1'b0;
    hold_clr        = 1'b0;
    if (clr) begin
      state_d     = ST_IDLE;
      prev_d      = '0;
      stall_d     = 1'b0;
      step_err_d  = 1'b0;
      err_value_d = '0;
      wc_clr      = 1'b1;
      hold_clr    = 1'b1;
    end else begin
      case (state)
        ST_TRACK: begin
          if (count == prev) begin
            hold_inc = 1'b1;
            // stall rises together with hold reaching MAX_HOLD
            if (hold >= HW'(MAX_HOLD - 1)) stall_d = 1'b1;
          end else begin
            hold_clr = 1'b1;
            stall_d  = 1'b0;
            prev_d   = count;
            if (prev == CMAX && count == '0) begin
              wrap_pulse_d = 1'b1;
              wc_inc       = 1'b1;
            end else if (count == '0) begin
              // prev is neither max nor 0 here: upstream restarted
              restart_pulse_d = 1'b1;
            end else if (count != prev_inc) begin
              step_err_d  = 1'b1;
              err_value_d = count;
              state_d     = ST_ERR;
            end
          end
        end
        ST_ERR: ;  // frozen until clr
        default: begin  // IDLE and the unused encoding
          prev_d   = count;
          state_d  = ST_TRACK;
          hold_clr = 1'b1;
          stall_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      prev          <= '0;
      stall         <= 1'b0;
      step_err      <= 1'b0;
      err_value     <= '0;
      wrap_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      prev          <= prev_d;
      stall         <= stall_d;
      step_err      <= step_err_d;
      err_value     <= err_value_d;
      wrap_pulse    <= wrap_pulse_d;
      restart_pulse <= restart_pulse_d;
    end
  end

  sat_counter #(.W(WC_W), .MAX({WC_W{1'b1}})) u_wrap_cnt (
    .clk(clk), .rst_n(reset), .inc(wc_inc), .clr(wc_clr), .q(wrap_count)
  );

  sat_counter #(.W(HW), .MAX(HW'(MAX_HOLD))) u_hold_cnt (
    .clk(clk), .rst_n(reset), .inc(hold_inc), .clr(hold_clr), .q(hold)
  );

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed self-checking bench for count_monitor
// (defaults CW=4, MAX_HOLD=3, WC_W=8).
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count = '0;
  logic       clr = 1'b0;
  logic       wrap_pulse, restart_pulse, stall, step_err;
  logic [7:0] wrap_count;
  logic [3:0] err_value;
  logic [1:0] state;

  int npass = 0;
  int ntotal = 0;

  count_monitor dut (
    .clk(clk), .reset(reset), .count(count), .clr(clr),
    .wrap_pulse(wrap_pulse), .restart_pulse(restart_pulse),
    .wrap_count(wrap_count), .stall(stall), .step_err(step_err),
    .err_value(err_value), .state(state)
  );

  always #5 clk = ~clk;

  // present one sample; returns 1 time unit after the edge that takes it
  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    count = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    ntotal++; if ({wrap_pulse, restart_pulse, stall, step_err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {wrap_pulse, restart_pulse, stall, step_err}); else npass++;
    ntotal++; if (wrap_count !== 8'd0) $display("FAIL reset_wrap_count got %0d want 0", wrap_count); else npass++;
    ntotal++; if (state !== 2'd0 || err_value !== 4'd0) $display("FAIL reset_state got %0d/%0d want 0/0", state, err_value); else npass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    int np;
    np = 0;
    drive(4'd0);
    ntotal++; if (state !== 2'd1) $display("FAIL idle_to_track got %0d want 1", state); else npass++;
    for (int v = 1; v < 16; v++) begin
      drive(4'(v));
      if (wrap_pulse) np++;
    end
    drive(4'd0);
    ntotal++; if (wrap_pulse !== 1'b1) $display("FAIL wrap_pulse got %b want 1", wrap_pulse); else npass++;
    ntotal++; if (wrap_count !== 8'd1) $display("FAIL wrap_count got %0d want 1", wrap_count); else npass++;
    if (wrap_pulse) np++;
    for (int v = 1; v < 4; v++) begin
      drive(4'(v));
      if (wrap_pulse) np++;
    end
    ntotal++; if (np != 1) $display("FAIL wrap_pulse_count got %0d want 1", np); else npass++;
    ntotal++; if (step_err !== 1'b0 || wrap_count !== 8'd1) $display("FAIL wrap_tail got err=%b wc=%0d want 0/1", step_err, wrap_count); else npass++;
  endtask

  task automatic test_restart();
    drive(4'd4); drive(4'd5); drive(4'd6);
    drive(4'd0);
    ntotal++; if (restart_pulse !== 1'b1 || wrap_pulse !== 1'b0) $display("FAIL restart_pulse got r=%b w=%b want 1/0", restart_pulse, wrap_pulse); else npass++;
    ntotal++; if (step_err !== 1'b0) $display("FAIL restart_no_err got %b want 0", step_err); else npass++;
    drive(4'd1);
    ntotal++; if (restart_pulse !== 1'b0 || step_err !== 1'b0 || state !== 2'd1) $display("FAIL restart_follow got r=%b e=%b s=%0d want 0/0/1", restart_pulse, step_err, state); else npass++;
  endtask

  task automatic test_stall();
    for (int v = 2; v < 10; v++) drive(4'(v));
    ntotal++; if (stall !== 1'b0) $display("FAIL stall_1st got %b want 0", stall); else npass++;
    drive(4'd9);
    drive(4'd9);
    ntotal++; if (stall !== 1'b0) $display("FAIL stall_3rd got %b want 0", stall); else npass++;
    drive(4'd9);
    ntotal++; if (stall !== 1'b1) $display("FAIL stall_4th got %b want 1", stall); else npass++;
    drive(4'd9);
    ntotal++; if (stall !== 1'b1) $display("FAIL stall_5th got %b want 1", stall); else npass++;
    drive(4'd10);
    ntotal++; if (stall !== 1'b0 || step_err !== 1'b0) $display("FAIL stall_drop got s=%b e=%b want 0/0", stall, step_err); else npass++;
  endtask

  task automatic test_err();
    drive(4'd0); drive(4'd1); drive(4'd2); drive(4'd3); drive(4'd4);
    drive(4'd7);
    ntotal++; if (step_err !== 1'b1 || err_value !== 4'd7 || state !== 2'd2) $display("FAIL err_set got e=%b v=%0d s=%0d want 1/7/2", step_err, err_value, state); else npass++;
    drive(4'd8); drive(4'd3);
    ntotal++; if (step_err !== 1'b1 || err_value !== 4'd7 || state !== 2'd2) $display("FAIL err_hold got e=%b v=%0d s=%0d want 1/7/2", step_err, err_value, state); else npass++;
    @(negedge clk);
    clr = 1'b1; count = 4'd5;
    @(posedge clk); #1;
    clr = 1'b0;
    ntotal++; if (state !== 2'd0 || step_err !== 1'b0 || err_value !== 4'd0 || stall !== 1'b0 || wrap_count !== 8'd0) $display("FAIL err_clr got s=%0d e=%b v=%0d st=%b wc=%0d want 0/0/0/0/0", state, step_err, err_value, stall, wrap_count); else npass++;
    drive(4'd5);
    ntotal++; if (state !== 2'd1) $display("FAIL clr_resume got %0d want 1", state); else npass++;
  endtask

  task automatic test_saturate();
    int np;
    np = 0;
    for (int v = 6; v < 16; v++) drive(4'(v));
    for (int i = 0; i < 300; i++)
      for (int v = 0; v < 16; v++) begin
        drive(4'(v));
        if (wrap_pulse) np++;
      end
    ntotal++; if (np != 300) $display("FAIL sat_pulses got %0d want 300", np); else npass++;
    ntotal++; if (wrap_count !== 8'd255) $display("FAIL sat_wrap_count got %0d want 255", wrap_count); else npass++;
    @(negedge clk);
    clr = 1'b1; count = 4'd0;
    @(posedge clk); #1;
    clr = 1'b0;
    ntotal++; if (wrap_pulse !== 1'b0 || wrap_count !== 8'd0 || state !== 2'd0) $display("FAIL clr_with_wrap got p=%b wc=%0d s=%0d want 0/0/0", wrap_pulse, wrap_count, state); else npass++;
  endtask

  task automatic test_async_reset();
    drive(4'd3); drive(4'd4); drive(4'd7);
    ntotal++; if (state !== 2'd2) $display("FAIL pre_reset_err got %0d want 2", state); else npass++;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    ntotal++; if ({wrap_pulse, restart_pulse, stall, step_err} !== 4'b0 || err_value !== 4'd0 || wrap_count !== 8'd0 || state !== 2'd0) $display("FAIL async_reset got s=%0d e=%b v=%0d", state, step_err, err_value); else npass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(4'd8);
    ntotal++; if (state !== 2'd1 || step_err !== 1'b0) $display("FAIL post_reset_idle got s=%0d e=%b want 1/0", state, step_err); else npass++;
    drive(4'd9);
    ntotal++; if (step_err !== 1'b0 || state !== 2'd1) $display("FAIL post_reset_track got s=%0d e=%b want 1/0", state, step_err); else npass++;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_restart();
    test_stall();
    test_err();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
